div_sequencer: RTL and testbench



---
 rtl/div_sequencer.sv | 97 +++++++++
 tb/tb_div_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Sequencer for the shared 16-by-8 restoring divider. It produces one quotient bit per clock.
// Divide-by-zero and 8-bit quotient overflow are screened in CHECK, so invalid operations end early.
module div_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] Dividend,
  input  logic [7:0]  Divisor,
  output logic [15:0] Remainder,
  output logic [15:0] RegDivisorOut,
  output logic [7:0]  Quotient,
  output logic        doneflag,
  output logic        busy,
  output logic        divzero,
  output logic        overflow
);

  // state | meaning
  // IDLE  | waiting for start; results held
  // CHECK | screen divide-by-zero and quotient overflow
  // ITER  | one restoring step per clock, 8 clocks
  // DONE  | raise doneflag, return to IDLE
  typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] div_latched;
  logic [2:0] count;
  logic       bad_op;

  // The quotient fits in 8 bits only when the dividend's upper byte is below the divisor.
  assign bad_op = (div_latched == 8'd0) || (Remainder[15:8] >= div_latched);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   state_nxt = bad_op ? DONE : ITER;
      ITER:    if (count == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      Remainder     <= 16'd0;
      RegDivisorOut <= 16'd0;
      Quotient      <= 8'd0;
      div_latched   <= 8'd0;
      count         <= 3'd0;
      doneflag      <= 1'b0;
      busy          <= 1'b0;
      divzero       <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == CHECK) || (state_nxt == ITER);
      case (state)
        IDLE: begin
          if (start) begin
            Remainder     <= Dividend;
            RegDivisorOut <= {1'b0, Divisor, 7'b0};
            div_latched   <= Divisor;
            Quotient      <= 8'd0;
            count         <= 3'd0;
            doneflag      <= 1'b0;
            divzero       <= 1'b0;
            overflow      <= 1'b0;
          end
        end
        CHECK: begin
          if (div_latched == 8'd0) begin
            divzero  <= 1'b1;
            Quotient <= 8'hFF;
          end else if (Remainder[15:8] >= div_latched) begin
            overflow <= 1'b1;
            Quotient <= 8'hFF;
          end
        end
        ITER: begin
          if (Remainder >= RegDivisorOut) begin
            Remainder <= Remainder - RegDivisorOut;
            Quotient  <= {Quotient[6:0], 1'b1};
          end else begin
            Quotient  <= {Quotient[6:0], 1'b0};
          end
          RegDivisorOut <= {1'b0, RegDivisorOut[15:1]};
          count         <= count + 3'd1;
        end
        DONE: doneflag <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer. The driver queues the expected result of each accepted start.
// The monitor pops an entry and checks it on every doneflag rise.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] Dividend = 16'd0;
  logic [7:0]  Divisor = 8'd0;
  logic [15:0] Remainder, RegDivisorOut;
  logic [7:0]  Quotient;
  logic        doneflag, busy, divzero, overflow;

  div_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .Dividend(Dividend), .Divisor(Divisor),
    .Remainder(Remainder), .RegDivisorOut(RegDivisorOut), .Quotient(Quotient),
    .doneflag(doneflag), .busy(busy), .divzero(divzero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
    int          lat;
    int          e0;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   checks = 0;
  int   passes = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compare on every rising doneflag.
  always @(negedge clk) begin
    if (doneflag && !prev_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", {24'd0, Quotient}, {24'd0, e.q});
        chk("remainder", {16'd0, Remainder}, {16'd0, e.r});
        chk("divzero", {31'd0, divzero}, {31'd0, e.dz});
        chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
        chk("latency", cycle - e.e0, e.lat);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
    prev_done = doneflag;
  end

  // Drive one start; after the accepting edge, queue the expectation and scramble the inputs.
  task automatic issue(input logic [15:0] dd, input logic [7:0] dv, input logic [7:0] q,
                       input logic [15:0] r, input logic dz, input logic ov, input bit push);
    exp_t e;
    @(negedge clk);
    Dividend = dd;
    Divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    Dividend = 16'($urandom);
    Divisor  = 8'($urandom);
    chk("busy_after_e0", {31'd0, busy}, 32'd1);
    chk("flags_clear_e0", {29'd0, doneflag, divzero, overflow}, 32'd0);
    if (push) begin
      e.q = q; e.r = r; e.dz = dz; e.ov = ov;
      e.lat = (dz || ov) ? 2 : 10;
      e.e0 = cycle;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!doneflag && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!doneflag) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic run(input logic [15:0] dd, input logic [7:0] dv, input logic [7:0] q,
                     input logic [15:0] r, input logic dz, input logic ov);
    issue(dd, dv, q, r, dz, ov, 1'b1);
    wait_done();
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {Remainder, RegDivisorOut}, 32'd0);
    chk("reset_flags", {20'd0, Quotient, doneflag, busy, divzero, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run(16'd1003, 8'd10, 8'd100, 16'd3, 1'b0, 1'b0);
    run(16'hFEFF, 8'hFF, 8'hFF, 16'h00FE, 1'b0, 1'b0);
    run(16'h00FE, 8'hFF, 8'h00, 16'h00FE, 1'b0, 1'b0);
    run(16'hFFFF, 8'h00, 8'hFF, 16'hFFFF, 1'b1, 1'b0);
    run(16'h1234, 8'h12, 8'hFF, 16'h1234, 1'b0, 1'b1);
    run(16'd1000, 8'd7, 8'd142, 16'd6, 1'b0, 1'b0);

    // A start pulsed during ITER with a different dividend must be ignored.
    issue(16'd5000, 8'd50, 8'd100, 16'd0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    Dividend = 16'd77;
    Divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("no_queued_start", {30'd0, busy, doneflag}, 32'd1);

    // Start held high launches back-to-back operations 11 edges apart.
    @(negedge clk);
    Dividend = 16'd255;
    Divisor  = 8'd16;
    start    = 1'b1;
    @(posedge clk);
    #1;
    e.q = 8'd15; e.r = 16'd15; e.dz = 1'b0; e.ov = 1'b0; e.lat = 10; e.e0 = cycle;
    sb.push_back(e);
    Dividend = 16'd300;
    Divisor  = 8'd2;
    repeat (11) @(posedge clk);
    #1;
    start = 1'b0;
    e.q = 8'd150; e.r = 16'd0; e.e0 = cycle;
    sb.push_back(e);
    chk("b2b_accept_busy", {31'd0, busy}, 32'd1);
    wait_done();

    // Reset at E5 aborts the operation with no doneflag.
    issue(16'd4321, 8'd99, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_outputs", {Remainder, RegDivisorOut}, 32'd0);
    chk("abort_flags", {20'd0, Quotient, doneflag, busy, divzero, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_no_done", {31'd0, doneflag}, 32'd0);
    run(16'd4321, 8'd99, 8'd43, 16'd64, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0]  dv, hi, lo;
      logic [15:0] dd;
      dv = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, int'(dv) - 1));
      lo = 8'($urandom);
      dd = {hi, lo};
      run(dd, dv, 8'(dd / {8'd0, dv}), dd % {8'd0, dv}, 1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
